// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit
//   Forwarding and hazard control for the 5-stage RV32I pipeline. A private
//   shadow pipeline (ex/mem/wb) mirrors the destination register, reg-write
//   and mem-read attributes of the instructions downstream of ID. The ID
//   operands are compared against it to:
//     - choose the EX operand mux sources (registered so they line up with
//       the instruction once it reaches EX),
//     - detect load-use hazards (1-cycle stall + bubble),
//     - flush IF/ID and ID/EX on a taken branch.
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   hold_i             global freeze; all state holds, stall_o/flush_o = 0
//   id_*_i             decoded fields of the instruction currently in ID
//   ex_branch_taken_i  EX resolved a taken branch/jump
//   forward_a_o/_b_o   operand mux selects: 0 regfile, 1 WB, 2 EX/MEM ALU
//   stall_o            hold PC and IF/ID, bubble into ID/EX
//   flush_o            kill IF/ID and ID/EX
//
// Optional feature (macro FWD_STATS_EN)
//   stall_cnt_o        edges on which stall_o was asserted
//   fwd_cnt_o          registering edges with any non-zero forward select
//   Both wrap modulo 2^STAT_W, clear on rst and hold under hold_i.
module fwd_hazard_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int STAT_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hold_i,
    input  logic                  id_valid_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_i,
    input  logic                  id_uses_rs1_i,
    input  logic                  id_uses_rs2_i,
    input  logic [REG_ADDR_W-1:0] id_rd_i,
    input  logic                  id_reg_write_i,
    input  logic                  id_mem_read_i,
    input  logic                  ex_branch_taken_i,
    output logic [1:0]            forward_a_o,
    output logic [1:0]            forward_b_o,
    output logic                  stall_o,
    output logic                  flush_o
`ifdef FWD_STATS_EN
   ,output logic [STAT_W-1:0]     stall_cnt_o,
    output logic [STAT_W-1:0]     fwd_cnt_o
`endif
);

    // Shadow pipeline: _p0 = EX entry, _p1 = MEM entry, _p2 = WB entry
    logic                  vld_p0, vld_p1, vld_p2;
    logic [REG_ADDR_W-1:0] rd_p0, rd_p1, rd_p2;
    logic                  rw_p0, rw_p1, rw_p2;
    logic                  mr_p0, mr_p1, mr_p2;

    logic       load_hit;
    logic       kill;
    logic [1:0] sel_a, sel_b;

    // Youngest producer wins. A load in EX has no result yet, so it is not
    // a forwarding source; that case is covered by the load-use stall.
    function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] rs,
                                           input logic                  uses);
        fwd_sel = 2'd0;
        if (uses && vld_p0 && rw_p0 && !mr_p0 && (rd_p0 != '0) && (rd_p0 == rs))
            fwd_sel = 2'd2;
        else if (uses && vld_p1 && rw_p1 && (rd_p1 != '0) && (rd_p1 == rs))
            fwd_sel = 2'd1;
    endfunction

    // ID stage: hazard detection and select computation
    always_comb begin
        flush_o  = ex_branch_taken_i & ~hold_i;
        load_hit = id_valid_i & vld_p0 & mr_p0 & (rd_p0 != '0) &
                   ((id_uses_rs1_i & (id_rs1_i == rd_p0)) |
                    (id_uses_rs2_i & (id_rs2_i == rd_p0)));
        stall_o  = load_hit & ~flush_o & ~hold_i;
        kill     = flush_o | stall_o;
        sel_a    = fwd_sel(id_rs1_i, id_uses_rs1_i);
        sel_b    = fwd_sel(id_rs2_i, id_uses_rs2_i);
    end

    // ID -> EX -> MEM -> WB boundary: control (valid bits, selects)
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0      <= 1'b0;
            vld_p1      <= 1'b0;
            vld_p2      <= 1'b0;
            forward_a_o <= 2'd0;
            forward_b_o <= 2'd0;
        end else if (!hold_i) begin
            vld_p2 <= vld_p1;
            vld_p1 <= vld_p0;
            vld_p0 <= id_valid_i & ~kill;
            if (kill) begin
                forward_a_o <= 2'd0;
                forward_b_o <= 2'd0;
            end else begin
                forward_a_o <= sel_a;
                forward_b_o <= sel_b;
            end
        end
    end

    // ID -> EX -> MEM -> WB boundary: entry payload, qualified by vld_pN
    always_ff @(posedge clk) begin
        if (!hold_i) begin
            rd_p2 <= rd_p1;
            rw_p2 <= rw_p1;
            mr_p2 <= mr_p1;
            rd_p1 <= rd_p0;
            rw_p1 <= rw_p0;
            mr_p1 <= mr_p0;
            rd_p0 <= id_rd_i;
            rw_p0 <= id_reg_write_i;
            mr_p0 <= id_mem_read_i;
        end
    end

`ifdef FWD_STATS_EN
    logic [STAT_W-1:0] stall_cnt_q, fwd_cnt_q;
    logic              fwd_event;

    assign fwd_event = ~hold_i & ~kill & ((sel_a != 2'd0) | (sel_b != 2'd0));

    // Statistics counters, updated on the same edges as the shadow pipeline
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else if (!hold_i) begin
            stall_cnt_q <= stall_cnt_q + {{(STAT_W-1){1'b0}}, stall_o};
            fwd_cnt_q   <= fwd_cnt_q + {{(STAT_W-1){1'b0}}, fwd_event};
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign fwd_cnt_o   = fwd_cnt_q;
`endif

    // The register file is write-first, so the WB entry never feeds a
    // forwarding decision; it is tracked only to keep the shadow complete.
    logic unused_wb;
`ifdef FWD_STATS_EN
    assign unused_wb = ^{vld_p2, rd_p2, rw_p2, mr_p2};
`else
    assign unused_wb = ^{vld_p2, rd_p2, rw_p2, mr_p2, STAT_W};
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
module tb_fwd_hazard_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       hold_i = 1'b0;
    logic       id_valid_i = 1'b0;
    logic [4:0] id_rs1_i = '0, id_rs2_i = '0, id_rd_i = '0;
    logic       id_uses_rs1_i = 1'b0, id_uses_rs2_i = 1'b0;
    logic       id_reg_write_i = 1'b0, id_mem_read_i = 1'b0;
    logic       ex_branch_taken_i = 1'b0;
    logic [1:0] forward_a_o, forward_b_o;
    logic       stall_o, flush_o;
`ifdef FWD_STATS_EN
    logic [31:0] stall_cnt_o, fwd_cnt_o;
`endif

    fwd_hazard_unit #(.REG_ADDR_W(5), .STAT_W(32)) dut (
        .clk(clk), .rst(rst), .hold_i(hold_i), .id_valid_i(id_valid_i),
        .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
        .id_uses_rs1_i(id_uses_rs1_i), .id_uses_rs2_i(id_uses_rs2_i),
        .id_rd_i(id_rd_i), .id_reg_write_i(id_reg_write_i),
        .id_mem_read_i(id_mem_read_i), .ex_branch_taken_i(ex_branch_taken_i),
        .forward_a_o(forward_a_o), .forward_b_o(forward_b_o),
        .stall_o(stall_o), .flush_o(flush_o)
`ifdef FWD_STATS_EN
       ,.stall_cnt_o(stall_cnt_o), .fwd_cnt_o(fwd_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       v;
        bit [4:0] rs1, rs2;
        bit       u1, u2;
        bit [4:0] rd;
        bit       rw, mr;
    } id_t;

    typedef struct {
        bit       v;
        bit [4:0] rd;
        bit       rw, mr;
    } ent_t;

    typedef struct {
        id_t      id;
        bit       br, hold;
        bit       e_stall, e_flush;
        bit [1:0] e_fa, e_fb;
    } vec_t;

    int total = 0;
    int bad   = 0;

    // Reference model: pipe[0]=EX, pipe[1]=MEM, pipe[2]=WB
    ent_t      m_pipe[3];
    bit [1:0]  m_fa, m_fb;
    bit [31:0] m_scnt, m_fcnt;
    id_t       cur;
    bit        cur_br, cur_hold, cur_rst;

    // Sampled values of the last cycle
    bit          s_stall, s_flush, m_stall_s, m_flush_s;
    logic [1:0]  s_fa, s_fb;
    logic [31:0] s_scnt, s_fcnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic id_t ins(input bit v, input int rs1, input int rs2, input bit u1,
                                input bit u2, input int rd, input bit rw, input bit mr);
        id_t r;
        r.v = v; r.rs1 = 5'(rs1); r.rs2 = 5'(rs2); r.u1 = u1; r.u2 = u2;
        r.rd = 5'(rd); r.rw = rw; r.mr = mr;
        return r;
    endfunction

    function automatic vec_t vec(input id_t id, input bit br, input bit hold, input bit es,
                                 input bit ef, input int fa, input int fb);
        vec_t r;
        r.id = id; r.br = br; r.hold = hold; r.e_stall = es; r.e_flush = ef;
        r.e_fa = 2'(fa); r.e_fb = 2'(fb);
        return r;
    endfunction

    // Load-use: ID reads a register that the load now in EX will produce.
    function automatic bit m_stall_f();
        bit hit;
        hit = 1'b0;
        if (cur.v && m_pipe[0].v && m_pipe[0].mr && m_pipe[0].rd != 0)
            hit = (cur.u1 && cur.rs1 == m_pipe[0].rd) || (cur.u2 && cur.rs2 == m_pipe[0].rd);
        return hit && !cur_br && !cur_hold;
    endfunction

    // Scan from youngest to oldest forwardable producer; EX yields 2, MEM yields 1.
    function automatic bit [1:0] m_sel(input bit [4:0] rs, input bit use_it);
        if (!use_it || rs == 0) return 2'd0;
        for (int i = 0; i < 2; i++) begin
            if (m_pipe[i].v && m_pipe[i].rw && m_pipe[i].rd == rs && !(i == 0 && m_pipe[i].mr))
                return 2'(2 - i);
        end
        return 2'd0;
    endfunction

    task automatic model_edge();
        bit       s;
        bit [1:0] sa, sb;
        if (cur_rst) begin
            for (int i = 0; i < 3; i++) m_pipe[i] = '{1'b0, 5'd0, 1'b0, 1'b0};
            m_fa = 0; m_fb = 0; m_scnt = 0; m_fcnt = 0;
        end else if (!cur_hold) begin
            s  = m_stall_f();
            sa = m_sel(cur.rs1, cur.u1);
            sb = m_sel(cur.rs2, cur.u2);
            if (s) m_scnt++;
            for (int i = 2; i > 0; i--) m_pipe[i] = m_pipe[i-1];
            if (cur_br || s) begin
                m_pipe[0].v = 1'b0;
                m_fa = 0; m_fb = 0;
            end else begin
                m_pipe[0] = '{cur.v, cur.rd, cur.rw, cur.mr};
                m_fa = sa; m_fb = sb;
                if (sa != 0 || sb != 0) m_fcnt++;
            end
        end
    endtask

    // Called just after a falling edge; returns just after the next one.
    task automatic run_cycle(input id_t id, input bit br, input bit hold, input bit r);
        cur = id; cur_br = br; cur_hold = hold; cur_rst = r;
        rst = r; hold_i = hold; ex_branch_taken_i = br;
        id_valid_i = id.v; id_rs1_i = id.rs1; id_rs2_i = id.rs2;
        id_uses_rs1_i = id.u1; id_uses_rs2_i = id.u2;
        id_rd_i = id.rd; id_reg_write_i = id.rw; id_mem_read_i = id.mr;
        #1;
        s_stall = stall_o; s_flush = flush_o;
        m_stall_s = m_stall_f(); m_flush_s = br && !hold;
        @(posedge clk);
        model_edge();
        #1;
        s_fa = forward_a_o; s_fb = forward_b_o;
`ifdef FWD_STATS_EN
        s_scnt = stall_cnt_o; s_fcnt = fwd_cnt_o;
`else
        s_scnt = 0; s_fcnt = 0;
`endif
        @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[$];
        id_t  idle, t;

        idle = ins(0, 0, 0, 0, 0, 0, 0, 0);

        // Directed program: ins(valid, rs1, rs2, uses1, uses2, rd, reg_write, mem_read)
        tbl.push_back(vec(ins(1, 1, 2, 1, 1, 5, 1, 0),   0, 0, 0, 0, 0, 0)); // 0 add x5,x1,x2
        tbl.push_back(vec(ins(1, 5, 3, 1, 1, 6, 1, 0),   0, 0, 0, 0, 2, 0)); // 1 sub x6,x5,x3
        tbl.push_back(vec(ins(1, 4, 4, 1, 1, 5, 1, 0),   0, 0, 0, 0, 0, 0)); // 2 add x5,x4,x4
        tbl.push_back(vec(idle,                          0, 0, 0, 0, 0, 0)); // 3 nop
        tbl.push_back(vec(ins(1, 4, 5, 1, 1, 7, 1, 0),   0, 0, 0, 0, 0, 1)); // 4 or x7,x4,x5
        tbl.push_back(vec(ins(1, 1, 0, 1, 0, 8, 1, 1),   0, 0, 0, 0, 0, 0)); // 5 lw x8,0(x1)
        tbl.push_back(vec(ins(1, 8, 8, 1, 1, 9, 1, 0),   0, 0, 1, 0, 0, 0)); // 6 add x9 (stall)
        tbl.push_back(vec(ins(1, 8, 8, 1, 1, 9, 1, 0),   0, 0, 0, 0, 1, 1)); // 7 add x9 again
        tbl.push_back(vec(ins(1, 1, 0, 1, 0, 0, 1, 0),   0, 0, 0, 0, 0, 0)); // 8 addi x0,x1,1
        tbl.push_back(vec(ins(1, 0, 0, 1, 1, 2, 1, 0),   0, 0, 0, 0, 0, 0)); // 9 add x2,x0,x0
        tbl.push_back(vec(ins(1, 1, 0, 1, 0, 0, 1, 1),   0, 0, 0, 0, 0, 0)); // 10 lw x0
        tbl.push_back(vec(ins(1, 0, 0, 1, 1, 3, 1, 0),   0, 0, 0, 0, 0, 0)); // 11 add x3,x0,x0
        tbl.push_back(vec(ins(1, 1, 0, 1, 0, 10, 1, 1),  0, 0, 0, 0, 0, 0)); // 12 lw x10
        tbl.push_back(vec(ins(1, 10, 2, 1, 1, 11, 1, 0), 1, 0, 0, 1, 0, 0)); // 13 load-use + branch
        tbl.push_back(vec(ins(1, 11, 10, 1, 1, 12, 1, 0),0, 0, 0, 0, 0, 1)); // 14 add x12,x11,x10
        tbl.push_back(vec(ins(1, 1, 2, 1, 1, 13, 1, 0),  0, 0, 0, 0, 0, 0)); // 15 add x13
        tbl.push_back(vec(ins(1, 13, 13, 1, 1, 14, 1, 0),0, 0, 0, 0, 2, 2)); // 16 sub x14,x13,x13
        for (int k = 0; k < 3; k++)                                           // 17-19 frozen
            tbl.push_back(vec(ins(1, 14, 14, 1, 1, 21, 1, 1), 1, 1, 0, 0, 2, 2));
        tbl.push_back(vec(ins(1, 14, 13, 1, 1, 15, 1, 0),0, 0, 0, 0, 2, 1)); // 20 add x15,x14,x13

        // Reset
        @(negedge clk);
        run_cycle(idle, 0, 0, 1);
        run_cycle(idle, 0, 0, 1);
        chk("reset_fwd_a", 32'(s_fa), 0);
        chk("reset_fwd_b", 32'(s_fb), 0);
`ifdef FWD_STATS_EN
        chk("reset_stall_cnt", s_scnt, 0);
        chk("reset_fwd_cnt", s_fcnt, 0);
`endif

        foreach (tbl[i]) begin
            run_cycle(tbl[i].id, tbl[i].br, tbl[i].hold, 0);
            chk($sformatf("row%0d_stall", i), 32'(s_stall), 32'(tbl[i].e_stall));
            chk($sformatf("row%0d_flush", i), 32'(s_flush), 32'(tbl[i].e_flush));
            chk($sformatf("row%0d_fwd_a", i), 32'(s_fa), 32'(tbl[i].e_fa));
            chk($sformatf("row%0d_fwd_b", i), 32'(s_fb), 32'(tbl[i].e_fb));
`ifdef FWD_STATS_EN
            if (i == 7) begin
                chk("stats_stall_cnt", s_scnt, 1);
                chk("stats_fwd_cnt", s_fcnt, 3);
            end
`endif
        end

        // Reset arriving on the edge of a load-use stall
        run_cycle(ins(1, 15, 0, 1, 0, 16, 1, 1), 0, 0, 0);      // lw x16,0(x15)
        chk("pre_rst_fwd_a", 32'(s_fa), 2);
        t = ins(1, 16, 16, 1, 1, 17, 1, 0);                      // add x17,x16,x16
        run_cycle(t, 0, 0, 1);
        chk("rst_stall_seen", 32'(s_stall), 1);
        chk("rst_fwd_a", 32'(s_fa), 0);
        chk("rst_fwd_b", 32'(s_fb), 0);
`ifdef FWD_STATS_EN
        chk("rst_stall_cnt", s_scnt, 0);
`endif
        run_cycle(t, 0, 0, 0);
        chk("post_rst_stall", 32'(s_stall), 0);
        chk("post_rst_fwd_a", 32'(s_fa), 0);
        chk("post_rst_fwd_b", 32'(s_fb), 0);

        // Random traffic against the reference model
        for (int n = 0; n < 600; n++) begin
            id_t r;
            bit  br, hd, rs;
            r.v  = 1'($urandom_range(0, 7) != 0);
            r.rs1 = 5'($urandom_range(0, 3));
            r.rs2 = 5'($urandom_range(0, 3));
            r.u1 = 1'($urandom_range(0, 3) != 0);
            r.u2 = 1'($urandom_range(0, 3) != 0);
            r.rd = 5'($urandom_range(0, 3));
            r.rw = 1'($urandom_range(0, 3) != 0);
            r.mr = 1'($urandom_range(0, 2) == 0);
            br = ($urandom_range(0, 7) == 0);
            hd = ($urandom_range(0, 7) == 0);
            rs = ($urandom_range(0, 59) == 0);
            run_cycle(r, br, hd, rs);
            chk("rand_stall", 32'(s_stall), 32'(m_stall_s));
            chk("rand_flush", 32'(s_flush), 32'(m_flush_s));
            chk("rand_fwd_a", 32'(s_fa), 32'(m_fa));
            chk("rand_fwd_b", 32'(s_fb), 32'(m_fb));
`ifdef FWD_STATS_EN
            chk("rand_stall_cnt", s_scnt, m_scnt);
            chk("rand_fwd_cnt", s_fcnt, m_fcnt);
`endif
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Produces the 2-bit select codes for the two EX-stage operand 3:1 muxes (forward A / forward B) of the 5-stage RV32I pipeline.
- Produces the load-use stall and branch flush controls.
- Tracks the destination register, reg-write and mem-read attributes of instructions in EX, MEM and WB with its own shadow pipeline.
- Registers the forward selects so they are aligned with the instruction in EX.

Parameters:
REG_ADDR_W, 5, register index width (x0..x31)
STAT_W, 32, width of the stats counters (only used with FWD_STATS_EN)

Ports:
clk  input  1  pipeline clock, rising edge
rst  input  1  synchronous, active-high reset
hold_i  input  1  global pipeline freeze (memory busy); all internal state holds
id_valid_i  input  1  ID stage holds a real instruction
id_rs1_i  input  REG_ADDR_W  ID source register 1
id_rs2_i  input  REG_ADDR_W  ID source register 2
id_uses_rs1_i  input  1  ID instruction reads rs1
id_uses_rs2_i  input  1  ID instruction reads rs2
id_rd_i  input  REG_ADDR_W  ID destination register
id_reg_write_i  input  1  ID instruction writes rd
id_mem_read_i  input  1  ID instruction is a load
ex_branch_taken_i  input  1  EX resolved a taken branch/jump
forward_a_o  output  2  select for the operand-A mux: 0 = regfile, 1 = WB result, 2 = EX/MEM ALU result
forward_b_o  output  2  select for the operand-B mux, same encoding
stall_o  output  1  hold PC and IF/ID, insert bubble into ID/EX
flush_o  output  1  kill IF/ID and ID/EX contents

Behaviour:
- Single clock domain, `clk`. `rst` is synchronous and active-high.
- Shadow pipeline: three entries, ex/mem/wb, each holding {valid, rd, reg_write, mem_read}.
- On reset: all entries are invalid, forward_a_o = forward_b_o = 2'd0, and the stats counters are cleared.
- Per-edge update priority: rst > hold_i > flush > stall > normal advance.
  - hold_i = 1: every register keeps its value. stall_o = 0 and flush_o = 0.
  - Normal advance: wb <= mem, mem <= ex, ex <= ID fields (valid = id_valid_i).
  - Flush (ex_branch_taken_i & ~hold_i): wb <= mem, mem <= ex, ex <= invalid, forward selects <= 0. The branch itself proceeds to MEM.
  - Stall (load-use): wb <= mem, mem <= ex, ex <= bubble (invalid), forward selects <= 0.
- Load-use stall, combinational:
  - stall_o = id_valid_i & ex.valid & ex.mem_read & ex.rd != 0 & ((id_uses_rs1_i & id_rs1_i == ex.rd) | (id_uses_rs2_i & id_rs2_i == ex.rd)) & ~flush & ~hold_i.
  - The stall lasts exactly 1 cycle. The following cycle the load sits in mem and forwarding selects 1.
- flush_o = ex_branch_taken_i & ~hold_i. Flush suppresses stall_o in the same cycle.
- Forward select for operand A, computed in ID and registered on the normal-advance edge (operand B is identical using rs2 / id_uses_rs2_i):
  - 2'd2 if ex.valid & ex.reg_write & ~ex.mem_read & ex.rd != 0 & ex.rd == id_rs1_i & id_uses_rs1_i.
  - Else 2'd1 if mem.valid & mem.reg_write & mem.rd != 0 & mem.rd == id_rs1_i & id_uses_rs1_i.
  - Else 2'd0.
- EX/MEM has priority over MEM/WB for the youngest producer.
- x0 is never forwarded. Code 2'd3 is never driven.
- A producer in WB while the consumer is in ID is not forwarded; the register file is write-first.
- Latency: the select is valid in the same cycle the consumer occupies EX, i.e. 1 clock after it leaves ID.
- Reset asserted mid-stall or mid-flush: all state clears at that edge. Outputs are 0 the next cycle.

Optional Feature:
- FWD_STATS_EN defined: adds outputs stall_cnt_o [STAT_W-1:0] and fwd_cnt_o [STAT_W-1:0].
  - stall_cnt_o increments on each edge where stall_o = 1.
  - fwd_cnt_o increments on each registering edge where either computed select is non-zero (+1 per edge, not per operand).
  - Both counters wrap modulo 2^STAT_W, clear on rst, and hold under hold_i.
- Not defined: no counters, no extra ports.

Test Plan:
- `add x5,x1,x2` then `sub x6,x5,x3` back-to-back -> `sub` in EX: forward_a_o = 2, forward_b_o = 0, stall_o never 1.
- `add x5,..`; `nop`; `or x7,x4,x5` -> `or` in EX: forward_b_o = 1, forward_a_o = 0.
- `lw x8,0(x1)`; `add x9,x8,x8` -> stall_o = 1 for exactly 1 cycle. Bubble follows. `add` in EX: forward_a_o = forward_b_o = 1.
- `addi x0,x1,1`; `add x2,x0,x0` -> both selects 0. `lw x0`; consumer of x0 -> no stall.
- ex_branch_taken_i = 1 in the same cycle as a load-use condition -> flush_o = 1, stall_o = 0, ex entry invalid next cycle.
- hold_i = 1 for 3 cycles mid-sequence -> selects and entries frozen, stall_o = 0. rst pulse during a stall -> selects 0 next cycle. With FWD_STATS_EN, the first three scenarios end with stall_cnt_o = 1, fwd_cnt_o = 3.
